// File: rtl/dmemu_ctrl_if.sv
// Data-memory bus bundle: req/gnt/rvalid handshake with addr, strobes, data.
// master = access controller, slave = data memory.
interface dmemu_ctrl_if;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_req,
    output o_bus_we,
    output o_bus_addr,
    output o_bus_be,
    output o_bus_wdata,
    input  i_bus_gnt,
    input  i_bus_rvalid,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_req,
    input  o_bus_we,
    input  o_bus_addr,
    input  o_bus_be,
    input  o_bus_wdata,
    output i_bus_gnt,
    output i_bus_rvalid,
    output i_bus_rdata
  );
endinterface

// File: rtl/dmemu_ctrl.sv
// MEM-stage data-memory controller: alignment check, bus req/gnt/rvalid, stall.
// Ports: pipeline access in, stall/done/misalign/timeout out, bus, formatter data.
module dmemu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_misalign,
  output logic        o_timeout,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_rd_addr,
  output logic [2:0]  o_rd_funct3,
  output logic        o_rd_is_load,
  dmemu_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0] CNT_LAST =
    16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] cnt;

  logic        in_idle;
  logic        in_req;
  logic        in_resp;
  logic        access;
  logic        misal;
  logic        accept;
  logic        complete;
  logic        expire;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;

  assign in_idle = (state == S_IDLE);
  assign in_req  = (state == S_REQ);
  assign in_resp = (state == S_RESP);

  assign access = i_valid & (i_is_load | i_is_store);

  // funct3[1:0]==11 cannot be decoded; it falls in the word bucket.
  assign misal =
    ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
    (i_funct3[1] & (i_addr[1:0] != 2'b00));

  assign accept = in_idle & access & ~misal;

  assign o_misalign = in_idle & access & misal;

  // Gated by reset so the pipeline is released the moment reset hits.
  assign o_stall = i_rst_n &
    (in_req | in_resp | accept);

  assign complete =
    (in_req & bus.i_bus_gnt & bus.i_bus_rvalid) |
    (in_resp & bus.i_bus_rvalid);

  // Completion wins over timeout in the same cycle.
  assign expire =
    (in_req | in_resp) & ~complete &
    (cnt == CNT_LAST);

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = i_wr_data;
    if (i_is_store) begin
      unique case (i_funct3[1:0])
        2'b00: begin
          be_nx    = 4'b0001 << i_addr[1:0];
          wdata_nx = {4{i_wr_data[7:0]}};
        end
        2'b01: begin
          be_nx    = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata_nx = {2{i_wr_data[15:0]}};
        end
        default: begin
          be_nx    = 4'b1111;
          wdata_nx = i_wr_data;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bus.o_bus_req   <= 1'b0;
      bus.o_bus_we    <= 1'b0;
      bus.o_bus_addr  <= '0;
      bus.o_bus_be    <= '0;
      bus.o_bus_wdata <= '0;
      o_rd_data       <= '0;
      o_rd_addr       <= '0;
      o_rd_funct3     <= '0;
      o_rd_is_load    <= 1'b0;
      o_done          <= 1'b0;
      o_timeout       <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state           <= S_REQ;
            cnt             <= '0;
            bus.o_bus_req   <= 1'b1;
            bus.o_bus_we    <= i_is_store;
            bus.o_bus_addr  <= {i_addr[31:2], 2'b00};
            bus.o_bus_be    <= be_nx;
            bus.o_bus_wdata <= wdata_nx;
            o_rd_addr       <= i_addr;
            o_rd_funct3     <= i_funct3;
            o_rd_is_load    <= i_is_load;
          end
        end
        S_REQ, S_RESP: begin
          if (complete) begin
            state         <= S_DONE;
            bus.o_bus_req <= 1'b0;
            o_done        <= 1'b1;
            if (o_rd_is_load) begin
              o_rd_data <= bus.i_bus_rdata;
            end
          end else if (expire) begin
            state         <= S_DONE;
            bus.o_bus_req <= 1'b0;
            o_done        <= 1'b1;
            o_timeout     <= 1'b1;
            o_rd_data     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            if (in_req & bus.i_bus_gnt) begin
              state         <= S_RESP;
              bus.o_bus_req <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // Still the same stalled instruction; i_valid is ignored.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmemu_ctrl.sv
// Directed bench for dmemu_ctrl: table of single accesses plus
// timeout, late-response and mid-access reset sequences.
module tb_dmemu_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        timeout;
  logic [31:0] rd_data;
  logic [31:0] rd_addr;
  logic [2:0]  rd_funct3;
  logic        rd_is_load;

  int checks = 0;
  int errors = 0;

  dmemu_ctrl_if bus ();

  dmemu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_is_load    (is_load),
    .i_is_store   (is_store),
    .i_funct3     (f3),
    .i_addr       (addr),
    .i_wr_data    (wd),
    .o_stall      (stall),
    .o_done       (done),
    .o_misalign   (misalign),
    .o_timeout    (timeout),
    .o_rd_data    (rd_data),
    .o_rd_addr    (rd_addr),
    .o_rd_funct3  (rd_funct3),
    .o_rd_is_load (rd_is_load),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gd;
    int          rd;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_lat;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] f, input logic ld, input logic st,
    input logic [31:0] a, input logic [31:0] w,
    input int gd, input int rd, input logic [31:0] rdat,
    input logic mis, input logic [31:0] ea,
    input logic [3:0] eb, input logic [31:0] ew,
    input int lat, input logic [31:0] er);
    vec_t v;
    v.f3 = f; v.ld = ld; v.st = st; v.addr = a; v.wd = w;
    v.gd = gd; v.rd = rd; v.rdata = rdat; v.mis = mis;
    v.e_addr = ea; v.e_be = eb; v.e_wd = ew;
    v.e_lat = lat; v.e_rd = er;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int t;
    int gat;
    int prot;
    int nreq;
    bit fin;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    valid = 1'b1; is_load = v.ld; is_store = v.st;
    f3 = v.f3; addr = v.addr; wd = v.wd;
    #1;
    chk({tag, "_idle_req"}, 32'(bus.o_bus_req), 32'd0);
    if (v.mis) begin
      chk({tag, "_misalign"}, 32'(misalign), 32'd1);
      chk({tag, "_mis_stall"}, 32'(stall), 32'd0);
      nreq = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.o_bus_req || stall || !misalign) nreq++;
      end
      chk({tag, "_mis_nobus"}, 32'(nreq), 32'd0);
      valid = 1'b0;
      return;
    end
    chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
    chk({tag, "_acc_mis"}, 32'(misalign), 32'd0);
    t = 0; gat = -1; prot = 0; fin = 1'b0;
    while (!fin && t < 40) begin
      @(negedge clk);
      t++;
      bus.i_bus_gnt = 1'b0;
      bus.i_bus_rvalid = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else begin
        if (!stall) prot++;
        if (bus.o_bus_req !== (gat < 0)) prot++;
        if (bus.o_bus_req &&
            (bus.o_bus_addr !== v.e_addr ||
             bus.o_bus_be !== v.e_be ||
             bus.o_bus_we !== v.st ||
             (v.st && bus.o_bus_wdata !== v.e_wd)))
          prot++;
        if (gat < 0 && t - 1 == v.gd) gat = t;
        bus.i_bus_gnt = (gat == t);
        if (gat >= 0 && t == gat + v.rd) begin
          bus.i_bus_rvalid = 1'b1;
          bus.i_bus_rdata = v.rdata;
        end
      end
    end
    if (!fin) begin
      chk({tag, "_done_seen"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(t), 32'(v.e_lat));
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
      chk({tag, "_done_stall"}, 32'(stall), 32'd0);
      chk({tag, "_rd_data"}, rd_data, v.e_rd);
      chk({tag, "_rd_addr"}, rd_addr, v.addr);
      chk({tag, "_rd_f3"}, 32'(rd_funct3), 32'(v.f3));
      chk({tag, "_rd_ld"}, 32'(rd_is_load), 32'(v.ld));
      chk({tag, "_protocol"}, 32'(prot), 32'd0);
    end
  endtask

  initial begin
    int n;
    bit fin;
    vec_t rv;
    bus.i_bus_gnt = 1'b0;
    bus.i_bus_rvalid = 1'b0;
    bus.i_bus_rdata = '0;

    tbl[0]  = mk(3'd2, 1, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                 0, 32'h100, 4'hF, 32'h0, 2, 32'hDEADBEEF);
    tbl[1]  = mk(3'd0, 0, 1, 32'h203, 32'h123456A5, 3, 2,
                 32'h0BADF00D, 0, 32'h200, 4'h8, 32'hA5A5A5A5,
                 7, 32'hDEADBEEF);
    tbl[2]  = mk(3'd1, 0, 1, 32'h302, 32'h0000BEEF, 0, 1,
                 32'h0, 0, 32'h300, 4'hC, 32'hBEEFBEEF,
                 3, 32'hDEADBEEF);
    tbl[3]  = mk(3'd1, 1, 0, 32'h301, 32'h0, 0, 0, 32'h0,
                 1, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    tbl[4]  = mk(3'd0, 1, 0, 32'h0F3, 32'h0, 1, 1, 32'h11223344,
                 0, 32'h0F0, 4'hF, 32'h0, 4, 32'h11223344);
    tbl[5]  = mk(3'd2, 0, 1, 32'h40C, 32'hCAFEF00D, 0, 0, 32'h0,
                 0, 32'h40C, 4'hF, 32'hCAFEF00D, 2, 32'h11223344);
    tbl[6]  = mk(3'd2, 1, 0, 32'h502, 32'h0, 0, 0, 32'h0,
                 1, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    tbl[7]  = mk(3'd1, 0, 1, 32'h101, 32'h1234, 0, 0, 32'h0,
                 1, 32'h0, 4'h0, 32'h0, 0, 32'h0);
    tbl[8]  = mk(3'd0, 0, 1, 32'h001, 32'h0000007E, 0, 0, 32'h0,
                 0, 32'h000, 4'h2, 32'h7E7E7E7E, 2, 32'h11223344);
    tbl[9]  = mk(3'd5, 1, 0, 32'h606, 32'h0, 2, 0, 32'hABCD1234,
                 0, 32'h604, 4'hF, 32'h0, 4, 32'hABCD1234);
    tbl[10] = mk(3'd1, 0, 1, 32'h700, 32'h99991357, 0, 0, 32'h0,
                 0, 32'h700, 4'h3, 32'h13571357, 2, 32'hABCD1234);
    tbl[11] = mk(3'd2, 1, 0, 32'h7FC, 32'h0, 7, 0, 32'h0F0F0F0F,
                 0, 32'h7FC, 4'hF, 32'h0, 9, 32'h0F0F0F0F);
    tbl[12] = mk(3'd4, 1, 0, 32'h802, 32'h0, 6, 1, 32'h5A5A5A5A,
                 0, 32'h800, 4'hF, 32'h0, 9, 32'h5A5A5A5A);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.o_bus_req), 32'd0);
    chk("rst_be", 32'(bus.o_bus_be), 32'd0);
    chk("rst_addr", bus.o_bus_addr, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    // Table-driven accesses, back to back
    for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

    // Timeout: grant never comes
    @(negedge clk);
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
    f3 = 3'd2; addr = 32'h900;
    #1;
    chk("to_idle_req", 32'(bus.o_bus_req), 32'd0);
    n = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (done) fin = 1'b1;
      else if (bus.o_bus_req) n++;
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_req_cycles", 32'(n), 32'(TO));
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_rd_data", rd_data, 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    bus.i_bus_rvalid = 1'b1;
    bus.i_bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus.i_bus_rvalid = 1'b0;
    chk("late_rd_data", rd_data, 32'd0);
    chk("late_done", 32'(done), 32'd0);
    chk("late_timeout", 32'(timeout), 32'd0);
    chk("late_req", 32'(bus.o_bus_req), 32'd0);

    // Reset while waiting in RESP
    @(negedge clk);
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0;
    f3 = 3'd2; addr = 32'hA00;
    @(negedge clk);
    chk("rr_req", 32'(bus.o_bus_req), 32'd1);
    bus.i_bus_gnt = 1'b1;
    @(negedge clk);
    bus.i_bus_gnt = 1'b0;
    chk("rr_resp_req", 32'(bus.o_bus_req), 32'd0);
    chk("rr_resp_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_async_req", 32'(bus.o_bus_req), 32'd0);
    chk("rr_async_stall", 32'(stall), 32'd0);
    chk("rr_async_done", 32'(done), 32'd0);
    chk("rr_async_rd_addr", rd_addr, 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rv = mk(3'd2, 1, 0, 32'hB04, 32'h0, 1, 0, 32'h600DCAFE,
            0, 32'hB04, 4'hF, 32'h0, 3, 32'h600DCAFE);
    run_vec(rv, 99);
    valid = 1'b0;
    @(negedge clk);
    chk("final_req", 32'(bus.o_bus_req), 32'd0);
    chk("final_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmemu_ctrl.md
# dmemu_ctrl

MEM-stage data-memory access controller sitting directly upstream of the load-data formatter. It accepts one load or store per instruction from the MEM stage, checks alignment, generates word-aligned bus address, byte strobes and replicated store data, and runs a req/gnt/rvalid handshake with data memory while stalling the pipeline. It hands the raw read word plus the latched funct3, address and load flag to the formatter.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+RESP before the access is abandoned; legal range 2..65535.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  MEM stage holds a valid instruction.
- i_is_load / i_is_store  in  1 each  access type; never both 1.
- i_funct3  in  3  RV32 load/store funct3.
- i_addr  in  32  effective byte address.
- i_wr_data  in  32  rs2 store data.
- o_stall  out  1  hold pipeline.
- o_done  out  1  one-cycle completion pulse.
- o_misalign  out  1  misaligned-access flag, combinational.
- o_timeout  out  1  one-cycle pulse, aligned with o_done, on abandoned access.
- o_bus_req / o_bus_we  out  1 each; i_bus_gnt  in  1.
- o_bus_addr  out  32  i_addr with [1:0] forced to 0.
- o_bus_be  out  4; o_bus_wdata  out  32.
- i_bus_rvalid  in  1; i_bus_rdata  in  32.
- o_rd_data  out  32  raw read word; o_rd_addr  out  32; o_rd_funct3  out  3; o_rd_is_load  out  1  to formatter.

## Operation
- Access = i_valid & (i_is_load | i_is_store). Misaligned = funct3[1:0]==01 & addr[0], or funct3[1:0]==10 & addr[1:0]!=0. funct3[1:0]==11 never arrives (decode guarantees); it is treated as a word access.
- FSM IDLE -> REQ -> RESP -> DONE -> IDLE.
- IDLE: access & misaligned -> o_misalign=1, no bus activity, o_stall=0, stay. Access & aligned -> o_stall=1 (combinational), capture bus fields and o_rd_addr/o_rd_funct3/o_rd_is_load, clear counter, go REQ.
- REQ: o_bus_req=1, bus fields held stable. gnt & rvalid -> DONE. gnt only -> RESP.
- RESP: o_bus_req=0; rvalid -> DONE.
- DONE: o_stall=0, o_done=1; i_valid ignored (same stalled instruction); go IDLE.
- o_stall=1 in REQ and RESP, and in IDLE on aligned access.
- Loads: we=0, be=1111; o_rd_data <= i_bus_rdata on the completing rvalid. Stores complete on rvalid too; o_rd_data unchanged.
- SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}. SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}. SW: be=1111, wdata=rs2.
- Timeout: counter increments each REQ/RESP cycle. If counter == TIMEOUT_CYCLES-1 in a cycle with no completing event -> DONE with o_timeout=1, o_rd_data <= 0, req dropped. Completion has priority over timeout in the same cycle.
- rvalid in IDLE/DONE (late response after timeout) is ignored.

## Timing
- Reset: state IDLE; all registered outputs 0 (o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, o_rd_data, o_rd_addr, o_rd_funct3, o_rd_is_load, o_done, o_timeout). Asserting reset mid-access drops o_bus_req immediately and abandons the access.
- Zero-wait memory (gnt+rvalid in first REQ cycle): T0 IDLE accept, T1 REQ, T2 DONE. o_stall high T0–T1, o_done at T2.
- Registered memory (rvalid one cycle after gnt): done at T3.
- o_rd_* outputs are valid from the DONE cycle and held until the next accept.
- Worst case: TIMEOUT_CYCLES cycles in REQ+RESP.

## Test plan
- LW addr 0x100, gnt+rvalid at T1, rdata 0xDEADBEEF -> o_bus_addr 0x100, be 1111, we 0; o_done at T2, o_rd_data 0xDEADBEEF; o_stall high exactly T0–T1.
- SB addr 0x203, rs2 0x123456A5, gnt after 3 cycles, rvalid 2 cycles later -> addr 0x200, be 1000, wdata 0xA5A5A5A5, we 1, req held until gnt, o_done 1 cycle after rvalid.
- SH addr 0x302 rs2 0x0000BEEF -> be 1100, wdata 0xBEEFBEEF. LH addr 0x301 -> o_misalign=1, o_stall=0, no o_bus_req.
- TIMEOUT_CYCLES=4, gnt never -> REQ for 4 cycles, then DONE with o_done=o_timeout=1 and o_rd_data 0. Late rvalid in IDLE is ignored.
- i_valid held high through DONE -> exactly one bus request per instruction; back-to-back LW/SW both complete in order.
- i_rst_n low in RESP -> o_bus_req, o_stall, o_done 0 asynchronously; after release, new LW completes normally.
